// File: rtl/game_screen_anim.sv
// game_screen_anim: animated full-screen generator for the red/green LED matrix.
// Windows a banner wider than the display onto a registered frame. The frame can
// be static, scroll left, blink, or scroll and blink, paced by a tick prescaler.
// done pulses after LOOPS full banner passes, after which the first banner
// window is held.
module game_screen_anim #(
  parameter int ROWS        = 16,
  parameter int COLS        = 16,
  parameter int TEXT_COLS   = 32,
  parameter int TICK_DIV    = 12_500_000,
  parameter int BLINK_TICKS = 2,
  parameter int LOOPS       = 2
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 start,
  input  logic                                 enable,
  input  logic [1:0]                           mode,
  input  logic [ROWS-1:0][TEXT_COLS-1:0]       RedBanner,
  input  logic [ROWS-1:0][TEXT_COLS-1:0]       GrnBanner,
  output logic [ROWS-1:0][COLS-1:0]            RedPixels,
  output logic [ROWS-1:0][COLS-1:0]            GrnPixels,
  output logic                                 busy,
  output logic                                 done
);

  localparam int PW  = (TICK_DIV    > 1) ? $clog2(TICK_DIV)    : 1;
  localparam int TW  = (TEXT_COLS   > 1) ? $clog2(TEXT_COLS)   : 1;
  localparam int LW  = (LOOPS       > 1) ? $clog2(LOOPS)       : 1;
  localparam int BW  = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam int TW1 = TW + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD} state_e;

  state_e                    state_q, state_d;
  logic [PW-1:0]             pre_q, pre_d;
  logic [TW-1:0]             pos_q, pos_d;
  logic [LW-1:0]             loop_q, loop_d;
  logic [BW-1:0]             blink_q, blink_d;
  logic                      phase_q, phase_d;
  logic [1:0]                mode_q, mode_d;
  logic                      done_d;
  logic                      tick;
  logic                      vis_d;
  logic [TW-1:0]             off_d;
  logic [ROWS-1:0][COLS-1:0] red_map, grn_map;
  logic [ROWS-1:0][COLS-1:0] red_q, grn_q;
  logic                      busy_q, done_q;

  assign tick = (state_q == S_RUN) && enable && (pre_q == PW'(TICK_DIV - 1));

  // Next-state for the sequencer, prescaler, position, loop and blink counters.
  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    pos_d   = pos_q;
    loop_d  = loop_q;
    blink_d = blink_q;
    phase_d = phase_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    if (start) begin
      state_d = S_RUN;
      pre_d   = '0;
      pos_d   = '0;
      loop_d  = '0;
      blink_d = '0;
      phase_d = 1'b1;
      mode_d  = mode;
    end else if (state_q == S_RUN && enable) begin
      if (tick) begin
        pre_d = '0;
        if (pos_q == TW'(TEXT_COLS - 1)) begin
          pos_d = '0;
          if (loop_q == LW'(LOOPS - 1)) begin
            loop_d  = '0;
            state_d = S_HOLD;
            done_d  = 1'b1;
          end else begin
            loop_d = loop_q + LW'(1);
          end
        end else begin
          pos_d = pos_q + TW'(1);
        end
        if (mode_q[1]) begin
          if (blink_q == BW'(BLINK_TICKS - 1)) begin
            blink_d = '0;
            phase_d = ~phase_q;
          end else begin
            blink_d = blink_q + BW'(1);
          end
        end
      end else begin
        pre_d = pre_q + PW'(1);
      end
    end
  end

  // Frame is built from next-state values so it lands together with the state.
  assign vis_d = ((state_d == S_RUN) && phase_d) || (state_d == S_HOLD);
  assign off_d = ((state_d == S_RUN) && mode_d[0]) ? pos_d : '0;

  // Per-column banner index: c - off + TEXT_COLS, folded once; no divider needed.
  for (genvar c = 0; c < COLS; c++) begin : g_col
    localparam logic [TW1-1:0] CBASE = TW1'(c + TEXT_COLS);
    logic [TW1-1:0] raw;
    logic [TW-1:0]  idx;
    assign raw = CBASE - {1'b0, off_d};
    assign idx = (raw >= TW1'(TEXT_COLS)) ? TW'(raw - TW1'(TEXT_COLS)) : raw[TW-1:0];
    for (genvar r = 0; r < ROWS; r++) begin : g_row
      assign red_map[r][c] = RedBanner[r][idx];
      assign grn_map[r][c] = GrnBanner[r][idx];
    end
  end

  // State, counters and registered outputs; reset clears everything at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      pre_q   <= '0;
      pos_q   <= '0;
      loop_q  <= '0;
      blink_q <= '0;
      phase_q <= 1'b1;
      mode_q  <= '0;
      red_q   <= '0;
      grn_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      pos_q   <= pos_d;
      loop_q  <= loop_d;
      blink_q <= blink_d;
      phase_q <= phase_d;
      mode_q  <= mode_d;
      red_q   <= vis_d ? red_map : '0;
      grn_q   <= vis_d ? grn_map : '0;
      busy_q  <= (state_d == S_RUN);
      done_q  <= done_d;
    end
  end

  assign RedPixels = red_q;
  assign GrnPixels = grn_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_game_screen_anim.sv
// Directed bench for game_screen_anim with a small banner and fast tick.
module tb_game_screen_anim;

  localparam int ROWS = 16;
  localparam int COLS = 16;
  localparam int TC   = 20;
  localparam int TD   = 4;
  localparam int BT   = 2;
  localparam int LP   = 1;

  typedef logic [ROWS-1:0][COLS-1:0] frame_t;
  typedef logic [ROWS-1:0][TC-1:0]   banner_t;

  typedef struct {
    logic [1:0] mode;
    int         cyc;
    int         off;
    bit         vis;
    bit         busy;
    bit         done;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       start = 1'b0;
  logic       enable = 1'b1;
  logic [1:0] mode = 2'd0;
  banner_t    red_b, grn_b;
  frame_t     red_px, grn_px;
  logic       busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  game_screen_anim #(
    .ROWS(ROWS), .COLS(COLS), .TEXT_COLS(TC),
    .TICK_DIV(TD), .BLINK_TICKS(BT), .LOOPS(LP)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .enable(enable), .mode(mode),
    .RedBanner(red_b), .GrnBanner(grn_b),
    .RedPixels(red_px), .GrnPixels(grn_px), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic frame_t model(banner_t b, int off, bit vis);
    frame_t f = '0;
    if (vis)
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          f[r][c] = b[r][(((c - off) % TC) + TC) % TC];
    return f;
  endfunction

  task automatic chk(string nm, logic [255:0] act, logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_frame(string nm, int off, bit vis, bit eb, bit ed);
    chk({nm, " red"},  red_px, model(red_b, off, vis));
    chk({nm, " grn"},  grn_px, model(grn_b, off, vis));
    chk({nm, " busy"}, {255'b0, busy}, {255'b0, eb});
    chk({nm, " done"}, {255'b0, done}, {255'b0, ed});
  endtask

  task automatic pulse_start(logic [1:0] m);
    @(negedge clk);
    mode  = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic vec_t mk(logic [1:0] m, int cyc, int off, bit vis, bit b, bit d);
    vec_t v;
    v.mode = m; v.cyc = cyc; v.off = off; v.vis = vis; v.busy = b; v.done = d;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    int k, cnt, first;
    bit bad;

    for (int c = 0; c < TC; c++)
      for (int r = 0; r < ROWS; r++) begin
        red_b[r][c] = (r == (c % 16));
        grn_b[r][c] = (((r + c) % 3) == 0);
      end

    // static
    vecs.push_back(mk(2'd0,  0, 0, 1, 1, 0));
    vecs.push_back(mk(2'd0,  3, 0, 1, 1, 0));
    vecs.push_back(mk(2'd0,  4, 0, 1, 1, 0));
    vecs.push_back(mk(2'd0, 79, 0, 1, 1, 0));
    vecs.push_back(mk(2'd0, 80, 0, 1, 0, 1));
    vecs.push_back(mk(2'd0, 81, 0, 1, 0, 0));
    // scroll
    vecs.push_back(mk(2'd1,  3, 0, 1, 1, 0));
    vecs.push_back(mk(2'd1,  4, 1, 1, 1, 0));
    vecs.push_back(mk(2'd1,  7, 1, 1, 1, 0));
    vecs.push_back(mk(2'd1,  8, 2, 1, 1, 0));
    vecs.push_back(mk(2'd1, 43, 10, 1, 1, 0));
    vecs.push_back(mk(2'd1, 79, 19, 1, 1, 0));
    vecs.push_back(mk(2'd1, 80, 0, 1, 0, 1));
    // blink
    vecs.push_back(mk(2'd2,  7, 0, 1, 1, 0));
    vecs.push_back(mk(2'd2,  8, 0, 0, 1, 0));
    vecs.push_back(mk(2'd2, 15, 0, 0, 1, 0));
    vecs.push_back(mk(2'd2, 16, 0, 1, 1, 0));
    vecs.push_back(mk(2'd2, 24, 0, 0, 1, 0));
    vecs.push_back(mk(2'd2, 80, 0, 1, 0, 1));
    // scroll + blink
    vecs.push_back(mk(2'd3,  8, 2, 0, 1, 0));
    vecs.push_back(mk(2'd3, 17, 4, 1, 1, 0));
    vecs.push_back(mk(2'd3, 80, 0, 1, 0, 1));

    // Reset and idle behaviour
    #2 reset_n = 1'b0;
    #1 chk_frame("reset", 0, 0, 0, 0);
    step(3);
    reset_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step(1);
      if (red_px !== '0 || grn_px !== '0 || busy !== 1'b0 || done !== 1'b0) bad = 1'b1;
    end
    chk("idle 50 cycles unchanged", {255'b0, bad}, 256'b0);

    // Table-driven checkpoints, each from a fresh start
    foreach (vecs[i]) begin
      pulse_start(vecs[i].mode);
      step(vecs[i].cyc);
      chk_frame($sformatf("vec%0d m%0d c%0d", i, vecs[i].mode, vecs[i].cyc),
                vecs[i].off, vecs[i].vis, vecs[i].busy, vecs[i].done);
    end

    // Single done pulse at cycle 80, then HOLD persists
    pulse_start(2'd1);
    cnt = 0; first = -1;
    for (int i = 0; i <= 120; i++) begin
      if (done === 1'b1) begin
        cnt++;
        if (first < 0) first = i;
      end
      step(1);
    end
    chk("scroll done count", cnt, 1);
    chk("scroll done cycle", first, 80);
    chk_frame("scroll hold", 0, 1, 0, 0);

    // Pause for 30 cycles mid-run
    pulse_start(2'd3);
    step(18);
    chk_frame("pause before", 4, 1, 1, 0);
    enable = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (red_px !== model(red_b, 4, 1) || grn_px !== model(grn_b, 4, 1) ||
          busy !== 1'b1 || done !== 1'b0) bad = 1'b1;
    end
    chk("pause frozen", {255'b0, bad}, 256'b0);
    enable = 1'b1;
    k = 48;
    while (k < 200 && done !== 1'b1) begin
      step(1);
      k++;
    end
    chk("pause run length", k, 110);

    // Restart mid-run
    pulse_start(2'd1);
    step(30);
    chk_frame("restart before", 7, 1, 1, 0);
    pulse_start(2'd1);
    chk_frame("restart cyc0", 0, 1, 1, 0);
    step(4);
    chk_frame("restart cyc4", 1, 1, 1, 0);
    k = 4;
    while (k < 200 && done !== 1'b1) begin
      step(1);
      k++;
    end
    chk("restart run length", k, 80);

    // Asynchronous reset mid-scroll
    pulse_start(2'd1);
    step(28);
    chk_frame("areset before", 7, 1, 1, 0);
    #2 reset_n = 1'b0;
    #1 chk_frame("areset immediate", 0, 0, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (red_px !== '0 || grn_px !== '0 || busy !== 1'b0 || done !== 1'b0) bad = 1'b1;
    end
    chk("areset stays idle", {255'b0, bad}, 256'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
